dmem_port_arbiter: RTL

- Shares the single data-memory port (mem_en/mem_wea/mem_rea/mem_addr/mem_din/mem_dout) between two requesters: the core Memory stage and an auxiliary master (UART programmer / debug loader).
- Serialises accesses and tracks read latency.
- Drives mem_hold, which stalls the core pipeline while a core access is waiting for a grant or for read data.
- Sits between the core bus and the memory controller.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 33 +++
 rtl/dmem_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, requester ids, limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

    // Encoding doubles as the bit index into the two-bit request/grant vectors.
    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_AUX  = 1'b1
    } req_id_t;

    localparam int MAX_RD_LAT = 7;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the one not served last.
// Latency: combinational grant; the fairness register updates on the edge ending an advancing cycle.
// Backpressure: caller masks req to zero when it cannot issue, so no grant is produced.
// Ports: clk/Rst, req[1:0] (bit0 core, bit1 aux), adv (issue cycle), gnt[1:0] one-hot or zero.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       Rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    req_id_t last;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == REQ_AUX) ? 2'b01 : 2'b10;
        end
    end

    // Reset to AUX so the core takes the very first tie.
    always_ff @(posedge clk) begin
        if (Rst) begin
            last <= REQ_AUX;
        end else if (adv && (gnt != 2'b00)) begin
            last <= gnt[1] ? REQ_AUX : REQ_CORE;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the core Memory stage and an aux master, tracking read latency.
// Latency: writes complete in the issue cycle; reads complete RD_LAT cycles after issue (data bypassed).
// Backpressure: core stalled via mem_hold; aux holds aux_req until the one-cycle aux_gnt pulse.
// Ports: core_* (core bus, stall mem_hold), aux_* (req/gnt, rvalid/rdata), mem_* (memory controller).
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int RD_LAT = 1,   // 1..MAX_RD_LAT
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              core_rea,
    input  logic              core_wea,
    input  logic [3:0]        core_en,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_din,
    output logic [31:0]       core_dout,
    output logic              mem_hold,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [3:0]        aux_be,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [31:0]       aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [31:0]       aux_rdata,
    output logic [3:0]        mem_en,
    output logic              mem_wea,
    output logic              mem_rea,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    localparam int                 CNT_W    = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0]   DONE_CNT = CNT_W'(RD_LAT);

    arb_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    req_id_t           own;
    logic [3:0]        rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [31:0]       core_dout_q;
    logic [31:0]       aux_rdata_q;

    logic       core_pend;
    logic       can_issue;
    logic [1:0] arb_req;
    logic [1:0] gnt;
    logic       core_gnt, aux_gnt_w;
    logic       rd_issue;
    logic       rd_done, core_done, aux_done;

    assign core_pend = core_rea | core_wea;
    // Reset cycles and every RD_WAIT cycle (completion included) are closed to new issues.
    assign can_issue = (state == IDLE) && !Rst;
    assign arb_req   = can_issue ? {aux_req, core_pend} : 2'b00;

    rr_arb2 u_arb (
        .clk (clk),
        .Rst (Rst),
        .req (arb_req),
        .adv (can_issue),
        .gnt (gnt)
    );

    assign core_gnt  = gnt[0];
    assign aux_gnt_w = gnt[1];
    // core_wea wins over core_rea, so a core grant without core_wea is a read.
    assign rd_issue  = (core_gnt && !core_wea) || (aux_gnt_w && !aux_we);
    assign rd_done   = (state == RD_WAIT) && (cnt == DONE_CNT) && !Rst;
    assign core_done = rd_done && (own == REQ_CORE);
    assign aux_done  = rd_done && (own == REQ_AUX);

    // State register
    always_ff @(posedge clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_issue) state_nxt = RD_WAIT;
            RD_WAIT: if (cnt == DONE_CNT) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read tracking and captured read data
    always_ff @(posedge clk) begin
        if (Rst) begin
            cnt         <= '0;
            own         <= REQ_CORE;
            rd_en_q     <= '0;
            rd_addr_q   <= '0;
            core_dout_q <= '0;
            aux_rdata_q <= '0;
        end else begin
            if (rd_issue) begin
                cnt       <= CNT_W'(1);
                own       <= core_gnt ? REQ_CORE : REQ_AUX;
                rd_en_q   <= mem_en;
                rd_addr_q <= mem_addr;
            end else if (state == RD_WAIT) begin
                cnt <= (cnt == DONE_CNT) ? '0 : cnt + CNT_W'(1);
            end
            if (core_done) core_dout_q <= mem_dout;
            if (aux_done)  aux_rdata_q <= mem_dout;
        end
    end

    // Outputs
    always_comb begin
        mem_en   = 4'b0000;
        mem_wea  = 1'b0;
        mem_rea  = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (core_gnt) begin
            mem_en   = core_en;
            mem_wea  = core_wea;
            mem_rea  = !core_wea;
            mem_addr = core_addr;
            mem_din  = core_din;
        end else if (aux_gnt_w) begin
            mem_en   = aux_be;
            mem_wea  = aux_we;
            mem_rea  = !aux_we;
            mem_addr = aux_addr;
            mem_din  = aux_wdata;
        end else if ((state == RD_WAIT) && !Rst) begin
            // Memory expects the read strobe and address held until data returns.
            mem_rea  = 1'b1;
            mem_en   = rd_en_q;
            mem_addr = rd_addr_q;
        end
    end

    assign aux_gnt    = aux_gnt_w;
    assign aux_rvalid = aux_done;
    assign mem_hold   = !Rst && core_pend && !((core_gnt && core_wea) || core_done);
    assign core_dout  = Rst ? 32'h0 : (core_done ? mem_dout : core_dout_q);
    assign aux_rdata  = Rst ? 32'h0 : (aux_done  ? mem_dout : aux_rdata_q);

endmodule
